// File: rtl/clm_inverter_seq.sv
// GF(2^8) inverse (x^254) of a CLM-encoded operand via 13 serial multiplier ops.
// Latency 13*(11+d)+1 cycles from start to done_o; starts while busy are ignored.
module clm_inverter_seq #(
  parameter int d = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [8+d-1:0]       x_i,
  input  logic [(9+d)*d-1:0]   rnd_i,
  output logic                 rnd_req_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [8+d-1:0]       y_o,
  output logic                 mul_start_o,
  output logic [8+d-1:0]       mul_p1_o,
  output logic [8+d-1:0]       mul_p2_o,
  output logic [(9+d)*d-1:0]   mul_rnd_o,
  input  logic [8+d-1:0]       mul_out_i,
  input  logic                 mul_done_i
);

  localparam int W = 8 + d;
  localparam logic [3:0] LAST_STEP = 4'd12;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    ARM   = 3'd2,
    WAIT  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t         state, state_nxt;
  logic [3:0]     step;
  logic [W-1:0]   x_saved;
  logic [W-1:0]   r;
  logic [W-1:0]   p1_q;
  logic [W-1:0]   p2_q;
  logic [W-1:0]   p2_sel;

  // Even steps square the running value, odd steps multiply it by x.
  assign p2_sel = step[0] ? x_saved : r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      step    <= '0;
      x_saved <= '0;
      r       <= '0;
      y_o     <= '0;
      p1_q    <= '0;
      p2_q    <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start_i) begin
            x_saved <= x_i;
            r       <= x_i;
            step    <= '0;
          end
        end
        ISSUE: begin
          p1_q <= r;
          p2_q <= p2_sel;
        end
        WAIT: begin
          if (mul_done_i) begin
            r <= mul_out_i;
            if (step == LAST_STEP) y_o <= mul_out_i;
            else                   step <= step + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt   = state;
    mul_start_o = 1'b0;
    rnd_req_o   = 1'b0;
    busy_o      = 1'b0;
    done_o      = 1'b0;
    mul_p1_o    = p1_q;
    mul_p2_o    = p2_q;
    case (state)
      IDLE: begin
        if (start_i) state_nxt = ISSUE;
      end
      ISSUE: begin
        mul_start_o = 1'b1;
        rnd_req_o   = 1'b1;
        busy_o      = 1'b1;
        mul_p1_o    = r;
        mul_p2_o    = p2_sel;
        state_nxt   = ARM;
      end
      ARM: begin
        // The multiplier's done level may still reflect the previous op here.
        busy_o    = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        busy_o = 1'b1;
        if (mul_done_i) state_nxt = (step == LAST_STEP) ? DONE : ISSUE;
      end
      DONE: begin
        done_o    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign mul_rnd_o = rnd_i;

endmodule
